// File: rtl/psum_spad_ctrl.sv
// psum_spad_ctrl: partial-sum scratchpad controller.
// Accumulates cfg_passes passes of cfg_num psums into the scratchpad and
// then drains the accumulated entries to a downstream consumer.
// Optional feature macro: PSUM_DRAIN_CLR_EN. When it is defined, each drained
// entry is also overwritten with zero (wr_zero) so that the scratchpad is
// clean for the next job.
//
// Handshake semantics (both mac_* and out_* pairs): a transfer happens on a
// rising clk edge where valid and ready are both high. valid, once raised,
// stays high with its address and flags stable until the transfer happens.
// ready may be asserted independently of valid.
module psum_spad_ctrl #(
    parameter int ADDR_W = 5,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_num,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              mac_valid,
    output logic              mac_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
`ifdef PSUM_DRAIN_CLR_EN
    output logic              wr_zero,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              first_pass,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [PASS_W-1:0] P_ONE = PASS_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wcnt, wcnt_nxt;
    logic [ADDR_W-1:0] rcnt, rcnt_nxt;
    logic [PASS_W-1:0] pass, pass_nxt;
    logic [ADDR_W-1:0] num_q, num_nxt;
    logic [PASS_W-1:0] passes_q, passes_nxt;

    logic wcnt_at_end;
    logic rcnt_at_end;
    logic pass_at_end;

    // The latched count is never zero while a job runs, so num_q-1 cannot
    // underflow; the largest legal count keeps both counters inside ADDR_W.
    assign wcnt_at_end = (wcnt == num_q - A_ONE);
    assign rcnt_at_end = (rcnt == num_q - A_ONE);
    assign pass_at_end = (pass == passes_q - P_ONE);

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // State, counter and latched-config registers; reset dominates clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            wcnt     <= '0;
            rcnt     <= '0;
            pass     <= '0;
            num_q    <= '0;
            passes_q <= '0;
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            rcnt     <= rcnt_nxt;
            pass     <= pass_nxt;
            num_q    <= num_nxt;
            passes_q <= passes_nxt;
        end
    end

    // Next-state, counter updates and all handshake/scratchpad outputs.
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        rcnt_nxt   = rcnt;
        pass_nxt   = pass;
        num_nxt    = num_q;
        passes_nxt = passes_q;
        mac_ready  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        first_pass = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        done       = 1'b0;
`ifdef PSUM_DRAIN_CLR_EN
        wr_zero    = 1'b0;
`endif

        case (state)
            IDLE: begin
                // A zero-sized job would never terminate cleanly; drop it.
                if (start && (cfg_num != '0) && (cfg_passes != '0)) begin
                    num_nxt    = cfg_num;
                    passes_nxt = cfg_passes;
                    wcnt_nxt   = '0;
                    rcnt_nxt   = '0;
                    pass_nxt   = '0;
                    state_nxt  = ACCUM;
                end
            end

            ACCUM: begin
                mac_ready  = 1'b1;
                first_pass = (pass == '0);
                if (mac_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = wcnt;
                    // Pass 0 writes the raw psum; later passes read-modify-write.
                    if (pass != '0) begin
                        rd_en   = 1'b1;
                        rd_addr = wcnt;
                    end
                    if (wcnt_at_end) begin
                        wcnt_nxt = '0;
                        pass_nxt = pass + P_ONE;
                        if (pass_at_end) begin
                            state_nxt = DRAIN;
                        end
                    end else begin
                        wcnt_nxt = wcnt + A_ONE;
                    end
                end
            end

            DRAIN: begin
                out_valid = 1'b1;
                rd_en     = 1'b1;
                rd_addr   = rcnt;
                out_last  = rcnt_at_end;
                if (out_ready) begin
                    rcnt_nxt = rcnt + A_ONE;
`ifdef PSUM_DRAIN_CLR_EN
                    wr_en    = 1'b1;
                    wr_addr  = rcnt;
                    wr_zero  = 1'b1;
`endif
                    if (rcnt_at_end) begin
                        state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over everything except reset, including a same-cycle start.
        if (clear) begin
            state_nxt = IDLE;
            wcnt_nxt  = '0;
            rcnt_nxt  = '0;
            pass_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_psum_spad_ctrl.sv
// Directed testbench for psum_spad_ctrl: accumulation addressing, first-pass
// flag, drain with stalls, clear/reset aborts, ignored starts and the
// full-range entry count.
module tb_psum_spad_ctrl;

    localparam int AW = 5;
    localparam int PW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          clear;
    logic          start;
    logic [AW-1:0] cfg_num;
    logic [PW-1:0] cfg_passes;
    logic          mac_valid;
    logic          mac_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
`ifdef PSUM_DRAIN_CLR_EN
    logic          wr_zero;
`endif
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          first_pass;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    psum_spad_ctrl #(.ADDR_W(AW), .PASS_W(PW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (clear),
        .start      (start),
        .cfg_num    (cfg_num),
        .cfg_passes (cfg_passes),
        .mac_valid  (mac_valid),
        .mac_ready  (mac_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
`ifdef PSUM_DRAIN_CLR_EN
        .wr_zero    (wr_zero),
`endif
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .first_pass (first_pass),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [AW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 ns after the active edge; outputs are sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic start_job(input int n, input int p);
        cfg_num    = AW'(n);
        cfg_passes = PW'(p);
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},      busy,       0);
        chk({tag, "_state"},     state_dbg,  0);
        chk({tag, "_mac_ready"}, mac_ready,  0);
        chk({tag, "_wr_en"},     wr_en,      0);
        chk({tag, "_wr_addr"},   wr_addr,    0);
        chk({tag, "_rd_en"},     rd_en,      0);
        chk({tag, "_rd_addr"},   rd_addr,    0);
        chk({tag, "_first"},     first_pass, 0);
        chk({tag, "_out_valid"}, out_valid,  0);
        chk({tag, "_out_last"},  out_last,   0);
        chk({tag, "_done"},      done,       0);
    endtask

    // n*p back-to-back MAC handshakes; expected write addresses come from exp_q.
    task automatic run_accum(input int n, input int p);
        for (int k = 0; k < n * p; k++) exp_q.push_back(AW'(k % n));
        for (int k = 0; k < n * p; k++) begin
            logic [AW-1:0] e;
            mac_valid = 1'b1;
            settle();
            e = exp_q.pop_front();
            chk("acc_state",   state_dbg,  1);
            chk("acc_ready",   mac_ready,  1);
            chk("acc_wr_en",   wr_en,      1);
            chk("acc_wr_addr", wr_addr,    e);
            chk("acc_first",   first_pass, (k < n));
            chk("acc_rd_en",   rd_en,      (k >= n));
            chk("acc_rd_addr", rd_addr,    (k >= n) ? e : 0);
            chk("acc_out_vld", out_valid,  0);
            cyc();
        end
        mac_valid = 1'b0;
    endtask

    // Drain n entries; bit (c % 16) of pat is out_ready in drain cycle c.
    task automatic run_drain(input int n, input logic [15:0] pat);
        int r = 0;
        int c = 0;
        bit fin = 0;
        while (!fin && c < 100) begin
            out_ready = pat[c % 16];
            settle();
            chk("drn_state",   state_dbg, 2);
            chk("drn_valid",   out_valid, 1);
            chk("drn_rd_en",   rd_en,     1);
            chk("drn_rd_addr", rd_addr,   r);
            chk("drn_last",    out_last,  (r == n - 1));
            chk("drn_mac_rdy", mac_ready, 0);
            chk("drn_done",    done,      0);
`ifdef PSUM_DRAIN_CLR_EN
            chk("drn_wr_en",   wr_en,     out_ready);
            chk("drn_wr_zero", wr_zero,   out_ready);
            if (out_ready) chk("drn_wr_addr", wr_addr, r);
`else
            chk("drn_wr_en",   wr_en,     0);
`endif
            if (out_ready) begin
                if (r == n - 1) fin = 1;
                r++;
            end
            c++;
            cyc();
        end
        out_ready = 1'b0;
        if (!fin) begin
            n_cmp++;
            n_fail++;
            $error("FAIL drain_timeout observed=%0d expected=%0d", r, n);
        end
        settle();
        chk("done_pulse", done,      1);
        chk("done_state", state_dbg, 3);
        chk("done_busy",  busy,      1);
        cyc();
        settle();
        chk("post_done",  done,      0);
        chk("post_busy",  busy,      0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn       = 1'b0;
        clear      = 1'b0;
        start      = 1'b0;
        cfg_num    = '0;
        cfg_passes = '0;
        mac_valid  = 1'b0;
        out_ready  = 1'b0;
        cyc();
        cyc();
        settle();
        chk_idle("reset");
        rstn = 1'b1;
        cyc();
        settle();
        chk_idle("idle");

        // Single pass of 3, constant mac_valid, drain always ready.
        start_job(3, 1);
        run_accum(3, 1);
        run_drain(3, 16'hFFFF);

        // 3 passes of 4 with one idle cycle first; drain stalls 1,0,0,1.
        start_job(4, 3);
        settle();
        chk("acc_idle_wr_en", wr_en,      0);
        chk("acc_idle_ready", mac_ready,  1);
        chk("acc_idle_first", first_pass, 1);
        cyc();
        run_accum(4, 3);
        run_drain(4, 16'hFFF9);

        // Clear at the 2nd handshake of pass 1, then a clean new job.
        start_job(4, 2);
        for (int k = 0; k < 6; k++) begin
            mac_valid = 1'b1;
            clear     = (k == 5);
            settle();
            chk("clr_wr_addr", wr_addr, k % 4);
            cyc();
        end
        clear     = 1'b0;
        mac_valid = 1'b0;
        settle();
        chk_idle("after_clear");
        cyc();
        settle();
        chk("after_clear_done", done, 0);
        start_job(2, 1);
        run_accum(2, 1);
        run_drain(2, 16'hFFFF);

        // clear together with start resolves to IDLE.
        clear = 1'b1;
        start_job(3, 1);
        clear = 1'b0;
        settle();
        chk("clr_start_busy", busy, 0);

        // Zero-sized jobs are ignored.
        start_job(0, 2);
        settle();
        chk("num0_busy", busy, 0);
        start_job(3, 0);
        settle();
        chk("pass0_busy", busy, 0);

        // start and config changes inside a job have no effect.
        start_job(2, 1);
        start      = 1'b1;
        cfg_num    = AW'(5);
        cfg_passes = PW'(3);
        run_accum(2, 1);
        start = 1'b0;
        run_drain(2, 16'hFFFF);

        // Largest entry count: 31 entries, drain every other cycle.
        start_job(31, 1);
        run_accum(31, 1);
        run_drain(31, 16'h5555);

        // Reset during DRAIN discards the job.
        start_job(2, 1);
        run_accum(2, 1);
        out_ready = 1'b0;
        settle();
        chk("pre_rst_valid", out_valid, 1);
        rstn = 1'b0;
        cyc();
        settle();
        chk_idle("rst_drain");
        rstn = 1'b1;
        cyc();
        settle();
        chk("rst_no_done", done, 0);
        chk("rst_no_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
